if_fetch_unit: RTL and testbench

Instruction-fetch stage that consumes the EX-stage redirect outputs (BranchAddress, JumpAddress, taken flags) and produces the IF/ID pipeline register contents (Instruction, PC_4) for decode. Owns the program counter, drives a request/acknowledge instruction-memory port with variable latency, and absorbs decode back-pressure with a one-entry skid buffer. When an EX redirect arrives while a fetch is outstanding, the stale response is discarded.

---
 rtl/if_fetch_pkg.sv | 14 +
 rtl/if_fetch_unit_if_id.sv | 48 ++++
 rtl/if_fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by if_fetch_unit and the IF/ID pipeline register.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCREMENT     = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/if_fetch_unit_if_id.sv
// IF/ID pipeline register: holds one instruction and its PC+4 with a valid bit.
// Flush clears only the valid bit; a bubble is taken when ID advances with no new word.
module if_id_register
    import if_fetch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_stall,
    input  logic         i_valid,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pc4,
    output logic [W-1:0] o_instr,
    output logic [W-1:0] o_pc4,
    output logic         o_valid
);

    logic [W-1:0] r_instr;
    logic [W-1:0] r_pc4;
    logic         r_valid;
    logic         w_advance;

    assign w_advance = !i_stall || !r_valid;

    // Pipeline register update: flush beats advance, advance without data leaves a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= {W{1'b0}};
            r_pc4   <= {W{1'b0}};
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_instr <= i_instr;
                r_pc4   <= i_pc4;
            end
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack imem port, one-entry skid, stale-response discard.
// Optional macro FETCH_DELAY_SLOT_EN: redirects leave the IF/ID register un-flushed.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter int               NBits    = 32,
    parameter logic [NBits-1:0] RESET_PC = NBits'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BranchTaken,
    input  logic             JumpTaken,
    input  logic [NBits-1:0] BranchAddress,
    input  logic [NBits-1:0] JumpAddress,
    input  logic             Stall,
    output logic             imem_req,
    output logic [NBits-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [NBits-1:0] imem_rdata,
    output logic [NBits-1:0] out_Instruction,
    output logic [NBits-1:0] out_PC_4,
    output logic             out_valid
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [NBits-1:0] r_pc;
    logic [NBits-1:0] r_target;
    logic [NBits-1:0] r_skid_instr;
    logic [NBits-1:0] r_skid_pc4;

    logic             w_redirect;
    logic [NBits-1:0] w_redir_tgt;
    logic [NBits-1:0] w_pc_plus4;
    logic             w_can_load;
    logic             w_flush;
    logic [NBits-1:0] w_pc_nxt;
    logic [NBits-1:0] w_tgt_nxt;
    logic             w_skid_ld;
    logic             w_id_vin;
    logic [NBits-1:0] w_id_instr;
    logic [NBits-1:0] w_id_pc4;

    assign w_redirect  = JumpTaken || BranchTaken;
    assign w_redir_tgt = JumpTaken ? JumpAddress : BranchAddress;
    assign w_pc_plus4  = r_pc + NBits'(PC_INCREMENT);
    assign w_can_load  = !Stall || !out_valid;

`ifdef FETCH_DELAY_SLOT_EN
    assign w_flush = 1'b0;
`else
    assign w_flush = w_redirect;
`endif

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack) begin
                    if (!w_redirect && !w_can_load) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else if (w_redirect) begin
                    w_state_nxt = ST_DISCARD;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (w_redirect || w_can_load) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Memory port outputs; the address only moves when the PC does.
    always_comb begin
        imem_addr = r_pc;
        if (reset || (r_state == ST_HOLD)) begin
            imem_req = 1'b0;
        end else begin
            imem_req = 1'b1;
        end
    end

    // PC, latched-target, skid and IF/ID-feed selection per state.
    always_comb begin
        w_pc_nxt   = r_pc;
        w_tgt_nxt  = r_target;
        w_skid_ld  = 1'b0;
        w_id_vin   = 1'b0;
        w_id_instr = imem_rdata;
        w_id_pc4   = w_pc_plus4;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack) begin
                    if (w_redirect) begin
                        w_pc_nxt = w_redir_tgt;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                        if (w_can_load) begin
                            w_id_vin = 1'b1;
                        end else begin
                            w_skid_ld = 1'b1;
                        end
                    end
                end else if (w_redirect) begin
                    w_tgt_nxt = w_redir_tgt;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_DISCARD: begin
                // A redirect arriving with the ack is the newest and wins.
                if (w_redirect) begin
                    w_tgt_nxt = w_redir_tgt;
                end else begin
                    w_tgt_nxt = r_target;
                end
                if (imem_ack) begin
                    w_pc_nxt = w_redirect ? w_redir_tgt : r_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt = w_redir_tgt;
                end else if (w_can_load) begin
                    w_id_vin   = 1'b1;
                    w_id_instr = r_skid_instr;
                    w_id_pc4   = r_skid_pc4;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    // PC, redirect target and skid storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_target     <= {NBits{1'b0}};
            r_skid_instr <= {NBits{1'b0}};
            r_skid_pc4   <= {NBits{1'b0}};
        end else begin
            r_pc     <= w_pc_nxt;
            r_target <= w_tgt_nxt;
            if (w_skid_ld) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc4   <= w_pc_plus4;
            end
        end
    end

    if_id_register #(
        .W(NBits)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_flush),
        .i_stall (Stall),
        .i_valid (w_id_vin),
        .i_instr (w_id_instr),
        .i_pc4   (w_id_pc4),
        .o_instr (out_Instruction),
        .o_pc4   (out_PC_4),
        .o_valid (out_valid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios, then randomized traffic
// against a queue-based reference model of the fetch stage.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        BranchTaken;
    logic        JumpTaken;
    logic [31:0] BranchAddress;
    logic [31:0] JumpAddress;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] out_Instruction;
    logic [31:0] out_PC_4;
    logic        out_valid;

    int n_checks;
    int n_fail;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    // Reference model: next fetch address, pending-drop flag, skid queue, IF/ID contents.
    word_t       m_skid[$];
    logic [31:0] m_pc;
    logic        m_drop;
    logic [31:0] m_drop_tgt;
    logic        m_id_valid;
    logic [31:0] m_id_instr;
    logic [31:0] m_id_pc4;

    logic        mem_busy;
    int          mem_cnt;

    if_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .BranchTaken     (BranchTaken),
        .JumpTaken       (JumpTaken),
        .BranchAddress   (BranchAddress),
        .JumpAddress     (JumpAddress),
        .Stall           (Stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .out_Instruction (out_Instruction),
        .out_PC_4        (out_PC_4),
        .out_valid       (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - 32'h0040_0000) >> 2;
        return 32'h2008_0001 + idx * 32'h0001_0001;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        logic        can_take;
        logic        have;
        word_t       w;
        if (reset) begin
            m_pc       = RST_PC;
            m_drop     = 1'b0;
            m_skid.delete();
            m_id_valid = 1'b0;
            m_id_instr = 32'd0;
            m_id_pc4   = 32'd0;
        end else begin
            have     = 1'b0;
            w        = '0;
            redir    = JumpTaken || BranchTaken;
            tgt      = JumpTaken ? JumpAddress : BranchAddress;
            can_take = !Stall || !m_id_valid;
            if (m_skid.size() != 0) begin
                if (redir) begin
                    m_skid.delete();
                    m_pc = tgt;
                end else if (can_take) begin
                    w    = m_skid.pop_front();
                    have = 1'b1;
                end
            end else if (m_drop) begin
                if (redir) m_drop_tgt = tgt;
                if (imem_ack) begin
                    m_pc   = m_drop_tgt;
                    m_drop = 1'b0;
                end
            end else if (imem_ack) begin
                if (redir) begin
                    m_pc = tgt;
                end else begin
                    w.instr = mem_word(m_pc);
                    w.pc4   = m_pc + 32'd4;
                    m_pc    = m_pc + 32'd4;
                    if (can_take) have = 1'b1;
                    else m_skid.push_back(w);
                end
            end else if (redir) begin
                m_drop     = 1'b1;
                m_drop_tgt = tgt;
            end
            if (redir && !DELAY_SLOT) begin
                m_id_valid = 1'b0;
            end else if (can_take) begin
                m_id_valid = have;
                if (have) begin
                    m_id_instr = w.instr;
                    m_id_pc4   = w.pc4;
                end
            end
        end
    endtask

    // One clock: drive inputs, check the request port, clock, check IF/ID.
    task automatic cycle(input logic rst, input logic ack, input logic stall,
                         input logic bt, input logic [31:0] ba,
                         input logic jt, input logic [31:0] ja);
        reset         = rst;
        imem_ack      = ack;
        Stall         = stall;
        BranchTaken   = bt;
        BranchAddress = ba;
        JumpTaken     = jt;
        JumpAddress   = ja;
        imem_rdata    = mem_word(imem_addr);
        #1;
        check_eq("imem_req", 32'(imem_req), 32'(!rst && (m_skid.size() == 0)));
        if (!rst && (m_skid.size() == 0)) check_eq("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(m_id_valid));
        check_eq("out_Instruction", out_Instruction, m_id_instr);
        check_eq("out_PC_4", out_PC_4, m_id_pc4);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
        return $urandom();
    endfunction

    initial begin
        logic        r_rst;
        logic        r_ack;
        logic        r_stall;
        logic        r_bt;
        logic        r_jt;
        int          r;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        Stall         = 1'b0;
        BranchTaken   = 1'b0;
        JumpTaken     = 1'b0;
        BranchAddress = 32'd0;
        JumpAddress   = 32'd0;
        mem_busy      = 1'b0;
        mem_cnt       = 0;
        m_pc          = RST_PC;
        m_drop        = 1'b0;
        m_drop_tgt    = 32'd0;
        m_id_valid    = 1'b0;
        m_id_instr    = 32'd0;
        m_id_pc4      = 32'd0;
        @(negedge clk);

        // Reset, then zero-wait memory streaming one word per cycle.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_pc4", out_PC_4, 32'd0);
        check_eq("seq_addr", imem_addr, 32'h0040_0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("first_pc4", out_PC_4, 32'h0040_0004);
        check_eq("first_valid", 32'(out_valid), 32'd1);
        check_eq("first_instr", out_Instruction, 32'h2008_0001);
        for (int k = 1; k < 6; k++) begin
            check_eq("seq_addr", imem_addr, 32'h0040_0000 + 32'(4 * k));
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        end
        check_eq("seq_instr", out_Instruction, 32'h200D_0006);

        // Slow ack, jump while the fetch is outstanding.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("held_addr", imem_addr, 32'h0040_0018);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0100);
        check_eq("held_addr", imem_addr, 32'h0040_0018);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("held_addr", imem_addr, 32'h0040_0018);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("dropped_valid", 32'(out_valid), 32'd0);
        check_eq("jump_addr", imem_addr, 32'h0040_0100);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("jump_pc4", out_PC_4, 32'h0040_0104);

        // Branch then jump while discarding: newest target wins.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0200);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0080);
        check_eq("discard_addr", imem_addr, 32'h0040_0104);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("newest_target", imem_addr, 32'h0040_0080);

        // Stall for four cycles with zero-wait memory.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check_eq("hold_req", 32'(imem_req), 32'd0);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        end
        check_eq("stall_pc4", out_PC_4, 32'h0040_0084);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("skid_pc4", out_PC_4, 32'h0040_0088);
        check_eq("skid_instr", out_Instruction, mem_word(32'h0040_0084));
        check_eq("resume_addr", imem_addr, 32'h0040_0088);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("resume_pc4", out_PC_4, 32'h0040_008C);

        // Redirect under Stall with a valid instruction in ID.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0300, 1'b0, 32'd0);
`ifdef FETCH_DELAY_SLOT_EN
        check_eq("slot_valid", 32'(out_valid), 32'd1);
        check_eq("slot_pc4", out_PC_4, 32'h0040_008C);
`else
        check_eq("squash_valid", 32'(out_valid), 32'd0);
        check_eq("squash_pc4", out_PC_4, 32'h0040_008C);
`endif
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("branch_addr", imem_addr, 32'h0040_0300);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Reset in the middle of a discard, with a late ack during reset.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0400);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0040_0000);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("post_rst_pc4", out_PC_4, 32'h0040_0004);

        // Randomized traffic with variable memory latency.
        mem_busy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(0, 199) == 0);
            r_stall = ($urandom_range(0, 99) < 35);
            r       = $urandom_range(0, 99);
            r_bt    = (r < 8);
            r_jt    = (r >= 5) && (r < 10);
            if (r_rst) begin
                mem_busy = 1'b0;
                r_ack    = 1'($urandom_range(0, 1));
            end else if (m_skid.size() == 0) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt  = $urandom_range(0, 3);
                end
                if (mem_cnt == 0) begin
                    r_ack    = 1'b1;
                    mem_busy = 1'b0;
                end else begin
                    r_ack   = 1'b0;
                    mem_cnt = mem_cnt - 1;
                end
            end else begin
                r_ack = 1'b0;
            end
            cycle(r_rst, r_ack, r_stall, r_bt, rand_addr(), r_jt, rand_addr());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
